// File: rtl/fifo_pkg.sv
// Shared defaults for the read-side FIFO stream consumer: word width, skid depth,
// transfer-counter width and the pointer-width helper used by the skid store.
package fifo_pkg;

  localparam int FIFO_DATA_W     = 8;
  localparam int FIFO_SKID_DEPTH = 4;
  localparam int FIFO_CNT_W      = 16;

  function automatic int fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Skid store for the FIFO stream reader: circular buffer of captured FIFO words with
// read/write pointers and an occupancy count; head word is always visible on rd_data.
module fifo_rd_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_SKID_DEPTH,
  parameter int PTR_W  = fifo_ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [PTR_W:0]    count
);

  logic [DATA_W-1:0] skid_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              rd_fire_s;

  // A read request against an empty store is ignored.
  assign rd_fire_s = rd_en && (count_q != (PTR_W+1)'(0));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_fire_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en, rd_fire_s})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= (PTR_W+1)'(0);
      for (int i = 0; i < DEPTH; i++) begin
        skid_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (wr_en) begin
        skid_q[wr_ptr_q] <= wr_data;
      end
    end
  end

  assign rd_data = skid_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-domain consumer for the dual-clock FIFO: pops words into a skid store and
// presents them as a first-word-fall-through valid/ready stream. FIFO_RD_COUNT_EN adds m_count.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W     = FIFO_DATA_W,
  parameter int SKID_DEPTH = FIFO_SKID_DEPTH
`ifdef FIFO_RD_COUNT_EN
  ,
  parameter int CNT_W      = FIFO_CNT_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_rempty,
  output logic              fifo_read_enable,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
`ifdef FIFO_RD_COUNT_EN
  ,
  output logic [CNT_W-1:0]  m_count
`endif
);

  localparam int PTR_W = fifo_ptr_w(SKID_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic             inflight_q;
  logic [OCC_W-1:0] count_s;
  logic [OCC_W-1:0] occ_s;
  logic             issue_s;
  logic             transfer_s;

  // Reserving a slot for the in-flight word means a capture can never find the store full.
  assign occ_s            = count_s + OCC_W'(inflight_q);
  assign issue_s          = !fifo_rempty && (occ_s < OCC_W'(SKID_DEPTH));
  assign fifo_read_enable = issue_s && !rst;
  assign m_valid          = (count_s != OCC_W'(0));
  assign transfer_s       = m_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue_s;
    end
  end

  fifo_rd_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (SKID_DEPTH),
    .PTR_W  (PTR_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight_q),
    .wr_data (fifo_rdata),
    .rd_en   (transfer_s),
    .rd_data (m_data),
    .count   (count_s)
  );

`ifdef FIFO_RD_COUNT_EN
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (transfer_s) begin
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
    end else begin
      xfer_cnt_d = xfer_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt_q <= CNT_W'(0);
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign m_count = xfer_cnt_q;
`else
  // Without the counter, transfers only advance the skid store.
`endif

endmodule
